// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed 6-digit display scanner:
// field encodings, scan FSM state type and the 7-segment code table.
package display_scan_ctrl_pkg;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_SEC  = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_HOUR = 2'd3;

  typedef enum logic {
    GUARD_S = 1'b0,
    SHOW_S  = 1'b1
  } scan_state_e;

  // Segment bit order {g,f,e,d,c,b,a}; codes 10..15 are dark.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b0000000, 7'b0000000,
    7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
  };

  function automatic logic [1:0] field_of(input logic [2:0] idx);
    logic [1:0] f;
    case (idx)
      3'd0, 3'd1: f = FIELD_SEC;
      3'd2, 3'd3: f = FIELD_MIN;
      default:    f = FIELD_HOUR;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_seg7_decode.sv
// Combinational BCD to 7-segment decoder; non-BCD codes produce a dark digit.
module seg7_decode
  import display_scan_ctrl_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[bcd_i];

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scanner for a 6-digit clock display with guard gaps,
// set-mode field blinking and leading-zero suppression of the hour tens digit.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int DWELL      = 2,
  parameter int GUARD      = 1,
  parameter int BLINK_HALF = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  d0,
  input  logic [3:0]  d1,
  input  logic [3:0]  d2,
  input  logic [3:0]  d3,
  input  logic [3:0]  d4,
  input  logic [3:0]  d5,
  input  logic        set_mode,
  input  logic [1:0]  sel_field,
  input  logic        blank_lead,
  output logic [6:0]  seg,
  output logic [5:0]  an,
  output logic [2:0]  scan_idx,
  output logic        frame_tick,
  output scan_state_e state_dbg
);

  scan_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  digit_q, digit_d;
  logic [5:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        ft_q, ft_d;
  logic [9:0]  bcnt_q, bcnt_d;
  logic        phase_q, phase_d;
  logic        set_mode_q;
  logic [1:0]  sel_q;

  logic [3:0]  live_digit;
  logic [6:0]  seg_raw;
  logic        restart;
  logic        blank_blink;
  logic        blank_zero;

  seg7_decode u_dec (
    .bcd_i (digit_d),
    .seg_o (seg_raw)
  );

  always_comb begin
    live_digit = 4'd0;
    case (idx_q)
      3'd0:    live_digit = d0;
      3'd1:    live_digit = d1;
      3'd2:    live_digit = d2;
      3'd3:    live_digit = d3;
      3'd4:    live_digit = d4;
      3'd5:    live_digit = d5;
      default: live_digit = 4'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    idx_d   = idx_q;
    digit_d = digit_q;
    case (state_q)
      GUARD_S: if (cnt_q == 8'(GUARD - 1)) begin
        state_d = SHOW_S;
        cnt_d   = 8'd0;
        digit_d = live_digit;
      end
      SHOW_S: if (cnt_q == 8'(DWELL - 1)) begin
        state_d = GUARD_S;
        cnt_d   = 8'd0;
        idx_d   = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      end
      default: state_d = GUARD_S;
    endcase

    // Blink phase restarts ON whenever the user enters set mode or picks a new field.
    restart = (set_mode && !set_mode_q) || (sel_field != sel_q);
    bcnt_d  = bcnt_q + 10'd1;
    phase_d = phase_q;
    if (restart) begin
      bcnt_d  = 10'd0;
      phase_d = 1'b1;
    end else if (bcnt_q == 10'(BLINK_HALF - 1)) begin
      bcnt_d  = 10'd0;
      phase_d = !phase_q;
    end

    blank_blink = set_mode && (sel_field != FIELD_NONE) &&
                  (sel_field == field_of(idx_d)) && !phase_d;
    blank_zero  = blank_lead && (idx_d == 3'd5) && (digit_d == 4'd0);

    // Outputs are computed from next-state so the registers line up with the FSM.
    an_d  = (state_d == SHOW_S) ? (6'd1 << idx_d) : 6'd0;
    seg_d = (state_d == SHOW_S && !blank_blink && !blank_zero) ? seg_raw : 7'd0;
    ft_d  = (state_d == SHOW_S) && (idx_d == 3'd5) && (cnt_d == 8'(DWELL - 1));
  end

  always_ff @(posedge clk) begin
    set_mode_q <= set_mode;
    sel_q      <= sel_field;
    if (rst) begin
      state_q <= GUARD_S;
      cnt_q   <= 8'd0;
      idx_q   <= 3'd0;
      digit_q <= 4'd0;
      an_q    <= 6'd0;
      seg_q   <= 7'd0;
      ft_q    <= 1'b0;
      bcnt_q  <= 10'd0;
      phase_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      digit_q <= digit_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      ft_q    <= ft_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign scan_idx   = idx_q;
  assign frame_tick = ft_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Cycle-level scoreboard bench: a timeline model predicts every output cycle
// from the input history; a negedge monitor compares against the DUT.
module tb_display_scan_ctrl;
  import display_scan_ctrl_pkg::*;

  localparam int DWELL      = 2;
  localparam int GUARD      = 1;
  localparam int BLINK_HALF = 4;
  localparam int P          = GUARD + DWELL;
  localparam int NCYC       = 2500;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  dv [6];
  logic        set_mode;
  logic [1:0]  sel_field;
  logic        blank_lead;
  logic [6:0]  seg;
  logic [5:0]  an;
  logic [2:0]  scan_idx;
  logic        frame_tick;
  scan_state_e state_dbg;

  display_scan_ctrl #(.DWELL(DWELL), .GUARD(GUARD), .BLINK_HALF(BLINK_HALF)) dut (
    .clk(clk), .rst(rst),
    .d0(dv[0]), .d1(dv[1]), .d2(dv[2]), .d3(dv[3]), .d4(dv[4]), .d5(dv[5]),
    .set_mode(set_mode), .sel_field(sel_field), .blank_lead(blank_lead),
    .seg(seg), .an(an), .scan_idx(scan_idx), .frame_tick(frame_tick),
    .state_dbg(state_dbg)
  );

  // input history, one entry per cycle
  logic       rst_h [NCYC+1];
  logic [3:0] d_h   [NCYC+1][6];
  logic       sm_h  [NCYC+1];
  logic [1:0] sel_h [NCYC+1];
  logic       bl_h  [NCYC+1];

  // scoreboard: {an, seg, scan_idx, frame_tick}
  logic [16:0] exp_q[$];
  int          cyc_q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [6:0] ref_decode(input int v);
    case (v)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic record(input int c);
    rst_h[c] = rst;
    for (int i = 0; i < 6; i++) d_h[c][i] = dv[i];
    sm_h[c]  = set_mode;
    sel_h[c] = sel_field;
    bl_h[c]  = blank_lead;
  endtask

  // monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [16:0] e;
      int          cy;
      e  = exp_q.pop_front();
      cy = cyc_q.pop_front();
      checks++;
      if ({an, seg, scan_idx, frame_tick} !== e) begin
        errors++;
        $display("FAIL scan_out cyc=%0d got an=%b seg=%b idx=%0d ft=%b exp an=%b seg=%b idx=%0d ft=%b",
                 cy, an, seg, scan_idx, frame_tick, e[16:11], e[10:4], e[3:1], e[0]);
      end
    end
  end

  // driver + reference model
  initial begin
    int  k, rref, slot, off, ent, dig, fld;
    bit  valid, show, ph_on, blk, done35, done37, done39;
    logic [5:0] e_an;
    logic [6:0] e_seg;
    logic       e_ft;

    k = 0; rref = 0; valid = 0; done35 = 0; done37 = 0; done39 = 0;
    rst = 1'b1; set_mode = 1'b0; sel_field = 2'd0; blank_lead = 1'b0;
    dv[0] = 4'd2; dv[1] = 4'd3; dv[2] = 4'd5; dv[3] = 4'd9; dv[4] = 4'd1; dv[5] = 4'd2;
    record(0);

    for (int c = 1; c <= NCYC; c++) begin
      @(posedge clk);
      #1;
      if (rst_h[c-1]) begin
        k = 0; rref = c; valid = 1;
      end else begin
        k++;
        if (c >= 2 && ((sm_h[c-1] && !sm_h[c-2]) || sel_h[c-1] != sel_h[c-2])) rref = c;
      end
      ph_on = (((c - rref) / BLINK_HALF) % 2) == 0;
      slot  = (k / P) % 6;
      off   = k % P;
      show  = off >= GUARD;
      e_an = 6'd0; e_seg = 7'd0; e_ft = 1'b0;
      if (show) begin
        ent = c - (off - GUARD);
        dig = int'(d_h[ent-1][slot]);
        fld = slot / 2 + 1;
        blk = (sm_h[c-1] && sel_h[c-1] != 2'd0 && int'(sel_h[c-1]) == fld && !ph_on) ||
              (bl_h[c-1] && slot == 5 && dig == 0);
        e_an  = 6'(1 << slot);
        e_seg = blk ? 7'd0 : ref_decode(dig);
        e_ft  = (slot == 5) && (off == P - 1);
      end
      if (valid) begin
        exp_q.push_back({e_an, e_seg, 3'(slot), e_ft});
        cyc_q.push_back(c);
      end

      // stimulus for cycle c
      rst = 1'b0;
      if (c < 3) rst = 1'b1;
      if (c == 41) dv[0] = 4'd4;
      if (c >= 60 && c <= 80 && !done35 && slot == 0 && off == GUARD) begin
        dv[0] = 4'd7; done35 = 1;
      end
      if (c == 81) begin set_mode = 1'b1; sel_field = 2'd2; end
      if (c >= 201 && !done37 && !ph_on) begin sel_field = 2'd3; done37 = 1; end
      if (c == 301) begin
        set_mode = 1'b0; sel_field = 2'd0; blank_lead = 1'b1; dv[5] = 4'd0; dv[0] = 4'd12;
      end
      if (c == 350) dv[5] = 4'd1;
      if (c == 400) blank_lead = 1'b0;
      if (c >= 401 && c <= 450 && !done39 && slot == 3 && show) begin
        rst = 1'b1; done39 = 1;
      end
      if (c > 450) begin
        if ($urandom_range(0, 3) == 0) dv[$urandom_range(0, 5)] = 4'($urandom_range(0, 11));
        if ($urandom_range(0, 39) == 0) set_mode = ~set_mode;
        if ($urandom_range(0, 29) == 0) sel_field = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 49) == 0) blank_lead = ~blank_lead;
        rst = ($urandom_range(0, 299) == 0);
      end
      record(c);
    end

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
